alu_exec_unit: RTL

Execute-stage ALU for the pipelined RV32I core. It consumes the 4-bit `ALUControl` produced by the ALU decoder, plus the ID/EX operands, and returns a registered `ALUResult`/`Zero` to the EX/MEM boundary. Add, sub, logic and compare ops complete in one cycle. Shifts (sll/srl/sra) use a serial one-bit-per-cycle shifter and stall the upstream stage through a ready/valid handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/serial_shifter.sv | 41 ++++
 rtl/alu_exec_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALUControl encodings and execute-stage FSM states shared with the ALU decoder
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic logic is_shift(input logic [3:0] op);
    case (op)
      ALU_SRA, ALU_SRL, ALU_SLL: is_shift = 1'b1;
      default: is_shift = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/serial_shifter.sv
// serial_shifter: one-bit-per-cycle shifter; result is the work reg shifted once more, valid when done
module serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  input  logic [XLEN-1:0]          a,
  output logic                     done,
  output logic [XLEN-1:0]          result
);
  localparam int SHAMT_W = $clog2(XLEN);
  logic [XLEN-1:0] work;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0] op_q;
  always_comb result = op_q == ALU_SLL ? {work[XLEN-2:0], 1'b0} :
                       op_q == ALU_SRA ? {work[XLEN-1], work[XLEN-1:1]} :
                                         {1'b0, work[XLEN-1:1]};
  assign done = cnt == SHAMT_W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      work <= '0;
      cnt  <= '0;
      op_q <= ALU_SRL;
    end else if (flush) begin
      cnt <= '0;
    end else if (start) begin
      work <= a;
      cnt  <= shamt;
      op_q <= op;
    end else if (cnt != '0) begin
      work <= result;
      cnt  <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute-stage ALU with registered result and serial shifts behind ready/valid
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [4:0]      RdE,
  output logic            out_valid,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic [4:0]      RdM
);
  localparam int SHAMT_W = $clog2(XLEN);
  state_t state, state_n;
  logic accept, start, done, load, fin;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0] alu_y, sh_y, res_d;
  logic [4:0] rd_q;
  assign shamt    = SrcB[SHAMT_W-1:0];
  assign in_ready = state == IDLE && !reset;
  assign accept   = in_valid && in_ready && !flush;
  assign start    = accept && is_shift(ALUControl) && shamt != '0;
  assign load     = accept && !start;
  assign fin      = state == SHIFT && done && !flush;
  assign res_d    = fin ? sh_y : alu_y;
  // shifts only reach this path with shamt 0, where the result is SrcA itself
  always_comb begin
    alu_y = '0;
    case (ALUControl)
      ALU_ADD:  alu_y = SrcA + SrcB;
      ALU_SUB:  alu_y = SrcA - SrcB;
      ALU_AND:  alu_y = SrcA & SrcB;
      ALU_OR:   alu_y = SrcA | SrcB;
      ALU_XOR:  alu_y = SrcA ^ SrcB;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, SrcA < SrcB};
      ALU_SRA, ALU_SRL, ALU_SLL: alu_y = SrcA;
      default:  alu_y = '0;
    endcase
  end
  always_comb state_n = flush ? IDLE : state == IDLE ? (start ? SHIFT : IDLE) : (done ? IDLE : SHIFT);
  serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .start(start),
    .op(ALUControl),
    .shamt(shamt),
    .a(SrcA),
    .done(done),
    .result(sh_y)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      RdM       <= '0;
      rd_q      <= '0;
    end else begin
      state     <= state_n;
      out_valid <= load || fin;
      if (load || fin) begin
        ALUResult <= res_d;
        Zero      <= res_d == '0;
        RdM       <= fin ? rd_q : RdE;
      end
      if (start) rd_q <= RdE;
    end
  end
endmodule
